// File: rtl/tmds_encoder.sv
// tmds_encoder: three-channel DVI TMDS 8b/10b encoder with per-channel running disparity.
// Define TMDS_ENCODER_GUARD_EN to insert the video guard band (latency grows from 2 to 4).
module tmds_encoder #(
    parameter int C_depth = 3
) (
    input  logic               clk_pixel,
    input  logic               reset_n,
    input  logic [C_depth-1:0] in_red,
    input  logic [C_depth-1:0] in_green,
    input  logic [C_depth-1:0] in_blue,
    input  logic               in_hsync,
    input  logic               in_vsync,
    input  logic               in_blank,
    output logic [9:0]         out_red,
    output logic [9:0]         out_green,
    output logic [9:0]         out_blue
);
    localparam int REP = (8 + C_depth - 1) / C_depth;

    localparam logic [9:0] CTRL_00 = 10'h354;
    localparam logic [9:0] CTRL_01 = 10'h0AB;
    localparam logic [9:0] CTRL_10 = 10'h154;
    localparam logic [9:0] CTRL_11 = 10'h2AB;

    // MSB-first replication of the palette value fills all 8 bits.
    function automatic logic [7:0] expand(input logic [C_depth-1:0] v);
        logic [REP*C_depth-1:0] rep;
        rep = {REP{v}};
        return rep[REP*C_depth-1 -: 8];
    endfunction

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [8:0] calc_qm(input logic [7:0] d);
        logic [8:0] q;
        logic [3:0] n1;
        logic       use_xnor;
        n1       = ones8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = CTRL_00;
            2'b01:   s = CTRL_01;
            2'b10:   s = CTRL_10;
            default: s = CTRL_11;
        endcase
        return s;
    endfunction

    // Channel index: 0 = blue (carries sync), 1 = green, 2 = red.
    logic [7:0]        d1 [3];
    logic              blank1;
    logic [1:0]        ctl1;

    logic [8:0]        qm      [3];
    logic signed [5:0] diff    [3];
    logic signed [5:0] cnt_x   [3];
    logic signed [5:0] cnt_sum [3];
    logic signed [4:0] cnt_d   [3];
    logic signed [4:0] cnt_q   [3];
    logic [9:0]        sym_d   [3];
    logic [9:0]        sym_q   [3];

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            for (int ch = 0; ch < 3; ch++) begin
                d1[ch] <= '0;
            end
            blank1 <= 1'b1;
            ctl1   <= '0;
        end else begin
            d1[0]  <= expand(in_blue);
            d1[1]  <= expand(in_green);
            d1[2]  <= expand(in_red);
            blank1 <= in_blank;
            ctl1   <= {in_vsync, in_hsync};
        end
    end

    always_comb begin
        for (int ch = 0; ch < 3; ch++) begin
            qm[ch]    = calc_qm(d1[ch]);
            // N1 - N0 over q_m[7:0] equals 2*N1 - 8.
            diff[ch]  = $signed({1'b0, ones8(qm[ch][7:0]), 1'b0}) - 6'sd8;
            cnt_x[ch] = {cnt_q[ch][4], cnt_q[ch]};
            if (blank1) begin
                sym_d[ch]   = (ch == 0) ? ctrl_sym(ctl1) : CTRL_00;
                cnt_sum[ch] = '0;
            end else if ((cnt_q[ch] == 5'sd0) || (diff[ch] == 6'sd0)) begin
                sym_d[ch]   = {~qm[ch][8], qm[ch][8],
                               qm[ch][8] ? qm[ch][7:0] : ~qm[ch][7:0]};
                cnt_sum[ch] = qm[ch][8] ? (cnt_x[ch] + diff[ch]) : (cnt_x[ch] - diff[ch]);
            end else if (((cnt_q[ch] > 5'sd0) && (diff[ch] > 6'sd0)) ||
                         ((cnt_q[ch] < 5'sd0) && (diff[ch] < 6'sd0))) begin
                sym_d[ch]   = {1'b1, qm[ch][8], ~qm[ch][7:0]};
                cnt_sum[ch] = cnt_x[ch] + (qm[ch][8] ? 6'sd2 : 6'sd0) - diff[ch];
            end else begin
                sym_d[ch]   = {1'b0, qm[ch][8], qm[ch][7:0]};
                cnt_sum[ch] = cnt_x[ch] + diff[ch] - (qm[ch][8] ? 6'sd0 : 6'sd2);
            end
            cnt_d[ch] = cnt_sum[ch][4:0];
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            for (int ch = 0; ch < 3; ch++) begin
                sym_q[ch] <= CTRL_00;
                cnt_q[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < 3; ch++) begin
                sym_q[ch] <= sym_d[ch];
                cnt_q[ch] <= cnt_d[ch];
            end
        end
    end

`ifdef TMDS_ENCODER_GUARD_EN
    localparam logic [9:0] GUARD_RB = 10'h2CC;
    localparam logic [9:0] GUARD_G  = 10'h133;

    logic       blank_q;
    logic       blank_d3;
    logic [9:0] sym_d3 [3];
    logic [9:0] out_q  [3];

    // Two extra stages give a two-symbol look-ahead on blank (blank_q, blank1)
    // so the last two control symbols before video can be swapped for guard band.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            blank_q  <= 1'b1;
            blank_d3 <= 1'b1;
            for (int ch = 0; ch < 3; ch++) begin
                sym_d3[ch] <= CTRL_00;
                out_q[ch]  <= CTRL_00;
            end
        end else begin
            blank_q  <= blank1;
            blank_d3 <= blank_q;
            for (int ch = 0; ch < 3; ch++) begin
                sym_d3[ch] <= sym_q[ch];
            end
            if (blank_d3 && (!blank_q || !blank1)) begin
                out_q[0] <= GUARD_RB;
                out_q[1] <= GUARD_G;
                out_q[2] <= GUARD_RB;
            end else begin
                for (int ch = 0; ch < 3; ch++) begin
                    out_q[ch] <= sym_d3[ch];
                end
            end
        end
    end

    assign out_blue  = out_q[0];
    assign out_green = out_q[1];
    assign out_red   = out_q[2];
`else
    assign out_blue  = sym_q[0];
    assign out_green = sym_q[1];
    assign out_red   = sym_q[2];
`endif

endmodule

// File: tb/tb_tmds_encoder.sv
// tb_tmds_encoder: randomized and directed checks of tmds_encoder against a
// behavioural TMDS model; honours TMDS_ENCODER_GUARD_EN.
module tb_tmds_encoder;
`ifdef TMDS_ENCODER_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam int LAT = GUARD ? 4 : 2;

    localparam logic [30:0] NOLIT = 31'd0;

    logic       clk_pixel;
    logic       reset_n;
    logic [2:0] in_red, in_green, in_blue;
    logic       in_hsync, in_vsync, in_blank;
    logic [9:0] out_red, out_green, out_blue;

    tmds_encoder #(.C_depth(3)) dut (
        .clk_pixel (clk_pixel),
        .reset_n   (reset_n),
        .in_red    (in_red),
        .in_green  (in_green),
        .in_blue   (in_blue),
        .in_hsync  (in_hsync),
        .in_vsync  (in_vsync),
        .in_blank  (in_blank),
        .out_red   (out_red),
        .out_green (out_green),
        .out_blue  (out_blue)
    );

    // Clock and reset
    initial begin
        clk_pixel = 1'b0;
        forever #20 clk_pixel = ~clk_pixel;
    end

    // Scoreboard: expected {red, green, blue}, blank flag, optional literal pin.
    logic [29:0] exp_q[$];
    bit          blk_q[$];
    logic [30:0] lit_q[$];
    int          cnt_m[3];
    int          total;
    int          bad;

    function automatic logic [30:0] mk_lit(input logic [9:0] r, input logic [9:0] g,
                                           input logic [9:0] b);
        return {1'b1, r, g, b};
    endfunction

    function automatic logic [7:0] expand3(input logic [2:0] v);
        int x;
        x = int'(v);
        return 8'((x << 5) | (x << 2) | (x >> 1));
    endfunction

    function automatic logic [9:0] ctrl_ref(input logic vs, input logic hs);
        logic [9:0] tab [4];
        tab = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
        return tab[{vs, hs}];
    endfunction

    // q_m[i] is the parity of D[0..i]; the XNOR variant also flips odd bits.
    function automatic logic [9:0] tmds_ref(input logic [7:0] d, input int ch);
        int         n1, n1q, n0q, p;
        bit         xn;
        logic [8:0] q;
        logic [7:0] m;
        logic [9:0] s;
        n1 = $countones(d);
        xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        for (int i = 0; i < 8; i++) begin
            m    = 8'((1 << (i + 1)) - 1);
            p    = $countones(d & m) % 2;
            q[i] = xn ? ((p ^ (i % 2)) != 0) : (p != 0);
        end
        q[8] = !xn;
        n1q  = $countones(q[7:0]);
        n0q  = 8 - n1q;
        if (cnt_m[ch] == 0 || n1q == n0q) begin
            s = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
            cnt_m[ch] += q[8] ? (n1q - n0q) : (n0q - n1q);
        end else if ((cnt_m[ch] > 0 && n1q > n0q) || (cnt_m[ch] < 0 && n0q > n1q)) begin
            s = {1'b1, q[8], ~q[7:0]};
            cnt_m[ch] += 2 * int'(q[8]) + (n0q - n1q);
        end else begin
            s = {1'b0, q[8], q[7:0]};
            cnt_m[ch] += (n1q - n0q) - 2 * (q[8] ? 0 : 1);
        end
        return s;
    endfunction

    function automatic void model_push(input logic [2:0] r, input logic [2:0] g,
                                       input logic [2:0] b, input logic hs, input logic vs,
                                       input logic bl, input logic [30:0] lit);
        logic [9:0] sr, sg, sb;
        int         n;
        if (bl) begin
            sr = 10'h354;
            sg = 10'h354;
            sb = ctrl_ref(vs, hs);
            for (int ch = 0; ch < 3; ch++) cnt_m[ch] = 0;
        end else begin
            sb = tmds_ref(expand3(b), 0);
            sg = tmds_ref(expand3(g), 1);
            sr = tmds_ref(expand3(r), 2);
            if (GUARD) begin
                n = exp_q.size();
                if (n >= 1 && blk_q[n-1]) begin
                    exp_q[n-1] = {10'h2CC, 10'h133, 10'h2CC};
                    if (n >= 2 && blk_q[n-2]) exp_q[n-2] = {10'h2CC, 10'h133, 10'h2CC};
                end
            end
        end
        exp_q.push_back({sr, sg, sb});
        blk_q.push_back(bl);
        lit_q.push_back(lit);
    endfunction

    task automatic check_out();
        logic [29:0] e;
        logic [30:0] l;
        bit          bflag;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty t=%0t got r=%h g=%h b=%h", $time,
                     out_red, out_green, out_blue);
        end else begin
            e     = exp_q.pop_front();
            bflag = blk_q.pop_front();
            l     = lit_q.pop_front();
            total++;
            if ({out_red, out_green, out_blue} !== e) begin
                bad++;
                $display("FAIL model_cmp t=%0t blank=%0d got r=%h g=%h b=%h expected r=%h g=%h b=%h",
                         $time, bflag, out_red, out_green, out_blue, e[29:20], e[19:10], e[9:0]);
            end
            if (l[30]) begin
                total++;
                if ({out_red, out_green, out_blue} !== l[29:0]) begin
                    bad++;
                    $display("FAIL literal_pin t=%0t got r=%h g=%h b=%h expected r=%h g=%h b=%h",
                             $time, out_red, out_green, out_blue, l[29:20], l[19:10], l[9:0]);
                end
            end
        end
    endtask

    task automatic check_reset(input string name);
        total++;
        if ({out_red, out_green, out_blue} !== {10'h354, 10'h354, 10'h354}) begin
            bad++;
            $display("FAIL %s t=%0t got r=%h g=%h b=%h expected 354 on all", name, $time,
                     out_red, out_green, out_blue);
        end
    endtask

    task automatic apply(input logic [2:0] r, input logic [2:0] g, input logic [2:0] b,
                         input logic hs, input logic vs, input logic bl);
        in_red   = r;
        in_green = g;
        in_blue  = b;
        in_hsync = hs;
        in_vsync = vs;
        in_blank = bl;
    endtask

    // Driver: check the symbol leaving the pipe, then present the next input.
    task automatic drive(input logic [2:0] r, input logic [2:0] g, input logic [2:0] b,
                         input logic hs, input logic vs, input logic bl,
                         input logic [30:0] lit);
        @(negedge clk_pixel);
        check_out();
        apply(r, g, b, hs, vs, bl);
        model_push(r, g, b, hs, vs, bl, lit);
    endtask

    task automatic do_reset(input logic hs, input logic vs, input logic [30:0] lit);
        @(negedge clk_pixel);
        reset_n  = 1'b0;
        in_blank = 1'b1;
        #1;
        check_reset("reset_async");
        repeat (2) @(negedge clk_pixel);
        check_reset("reset_hold");
        @(negedge clk_pixel);
        exp_q.delete();
        blk_q.delete();
        lit_q.delete();
        for (int ch = 0; ch < 3; ch++) cnt_m[ch] = 0;
        reset_n = 1'b1;
        apply(3'd0, 3'd0, 3'd0, hs, vs, 1'b1);
        for (int i = 0; i < LAT - 1; i++) begin
            exp_q.push_back({10'h354, 10'h354, 10'h354});
            blk_q.push_back(1'b1);
            lit_q.push_back(NOLIT);
        end
        model_push(3'd0, 3'd0, 3'd0, hs, vs, 1'b1, lit);
    endtask

    initial begin
        logic [30:0] l;
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        apply(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);

        do_reset(1'b1, 1'b0, mk_lit(10'h354, 10'h354, 10'h0AB));
        repeat (2) drive(0, 0, 0, 0, 0, 1, NOLIT);

        // Black run: cnt -8, +2, -6
        drive(0, 0, 0, 0, 0, 0, mk_lit(10'h100, 10'h100, 10'h100));
        drive(0, 0, 0, 0, 0, 0, mk_lit(10'h3FF, 10'h3FF, 10'h3FF));
        drive(0, 0, 0, 0, 0, 0, mk_lit(10'h100, 10'h100, 10'h100));
        // One blank cycle clears the disparity
        drive(0, 0, 0, 0, 0, 1, NOLIT);
        drive(0, 0, 0, 1, 1, 0, mk_lit(10'h100, 10'h100, 10'h100));

        // White run: cnt -8, -2
        repeat (2) drive(0, 0, 0, 0, 0, 1, NOLIT);
        drive(7, 7, 7, 0, 0, 0, mk_lit(10'h200, 10'h200, 10'h200));
        drive(7, 7, 7, 0, 0, 0, mk_lit(10'h0FF, 10'h0FF, 10'h0FF));

        // Single-pixel red pulse between blanking
        repeat (2) drive(0, 0, 0, 0, 0, 1, NOLIT);
        drive(7, 0, 0, 0, 0, 0, mk_lit(10'h200, 10'h100, 10'h100));
        repeat (2) drive(0, 0, 0, 0, 0, 1, NOLIT);

        // 10-cycle blank then active: last two blank symbols carry guard band if enabled
        for (int i = 0; i < 10; i++) begin
            if (i >= 8)
                l = GUARD ? mk_lit(10'h2CC, 10'h133, 10'h2CC) : mk_lit(10'h354, 10'h354, 10'h154);
            else
                l = NOLIT;
            drive(0, 0, 0, 0, 1, 1, l);
        end
        drive(0, 0, 0, 0, 0, 0, mk_lit(10'h100, 10'h100, 10'h100));

        // Random traffic with single-cycle blank pulses and a mid-frame reset
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), NOLIT);
            end else begin
                drive(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), NOLIT);
            end
        end
        repeat (LAT) drive(0, 0, 0, 0, 0, 1, NOLIT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
